// File: rtl/bram_access_pkg.sv
// Shared definitions for the block-RAM access responder: FSM state encoding,
// default SDRAM-like latencies and small helpers.
package bram_access_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REFRESH,
    ST_WRITE_SETUP,
    ST_WRITE_BURST,
    ST_READ_SETUP,
    ST_READ_BURST,
    ST_RECOVER
  } bram_state_e;

  localparam int unsigned DEF_ADDR_WIDTH     = 16;
  localparam int unsigned DEF_WRITE_LATENCY  = 2;
  localparam int unsigned DEF_READ_LATENCY   = 3;
  localparam int unsigned DEF_REFRESH_CYCLES = 8;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned LEN_W = 10;

  // A zero-length request still moves one word.
  function automatic logic [LEN_W-1:0] burst_len(input logic [LEN_W-1:0] n);
    return (n == '0) ? LEN_W'(1) : n;
  endfunction

endpackage

// File: rtl/bram_access_array.sv
// Single-port 16-bit synchronous RAM with a one-cycle registered read.
// Contents are never reset.
module bram_access_array #(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [15:0]           wdata,
  output logic [15:0]           rdata
);

  logic [15:0] mem_q [0:(1<<ADDR_WIDTH)-1];
  logic [15:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we) mem_q[addr] <= wdata;
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bram_access_responder.sv
// Block-RAM target for the RAM bridge handshake, mimicking SDRAM setup
// latency, burst timing and refresh busy windows.
module bram_access_responder
  import bram_access_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned WRITE_LATENCY  = DEF_WRITE_LATENCY,
  parameter int unsigned READ_LATENCY   = DEF_READ_LATENCY,
  parameter int unsigned REFRESH_CYCLES = DEF_REFRESH_CYCLES
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [24:0] address,
  input  logic [9:0]  access_num,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  input  logic        write_request,
  input  logic        read_request,
  input  logic        enable_refresh,
  output logic        write_flag,
  output logic        read_flag,
  output logic        idle,
  output logic        refresh_mode
);

  bram_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic                  pending_q, pending_d;
  logic                  write_flag_q, write_flag_d;
  logic                  read_flag_q, read_flag_d;
  logic                  refresh_mode_q, refresh_mode_d;
  logic                  idle_q, idle_d;
  logic [15:0]           dout_q, dout_d;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [15:0]           ram_rdata;
  logic                  enter_refresh;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^address[24:ADDR_WIDTH];

  bram_access_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (data_in),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    base_d        = base_q;
    len_d         = len_q;
    ram_we        = 1'b0;
    ram_addr      = base_q + ADDR_WIDTH'(cnt_q);
    // A pulse arriving while IDLE is honoured immediately, ahead of requests.
    enter_refresh = (state_q == ST_IDLE) && (pending_q || enable_refresh);

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (enter_refresh) begin
          state_d = ST_REFRESH;
        end else if (write_request || read_request) begin
          state_d = write_request ? ST_WRITE_SETUP : ST_READ_SETUP;
          base_d  = address[ADDR_WIDTH-1:0];
          len_d   = burst_len(access_num);
        end
      end
      ST_REFRESH: begin
        if (cnt_q == CNT_W'(REFRESH_CYCLES - 1)) state_d = ST_RECOVER;
        else                                     cnt_d   = cnt_q + 1'b1;
      end
      ST_WRITE_SETUP: begin
        if (cnt_q == CNT_W'(WRITE_LATENCY - 1)) begin
          state_d = ST_WRITE_BURST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WRITE_BURST: begin
        ram_we = 1'b1;
        if (cnt_q == CNT_W'(len_q - 1'b1)) state_d = ST_RECOVER;
        else                               cnt_d   = cnt_q + 1'b1;
      end
      ST_READ_SETUP: begin
        // Word 0 is fetched during setup so it is ready on the first flag cycle.
        ram_addr = base_q;
        if (cnt_q == CNT_W'(READ_LATENCY - 1)) begin
          state_d = ST_READ_BURST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READ_BURST: begin
        ram_addr = base_q + ADDR_WIDTH'(cnt_q + 1'b1);
        if (cnt_q == CNT_W'(len_q - 1'b1)) state_d = ST_RECOVER;
        else                               cnt_d   = cnt_q + 1'b1;
      end
      ST_RECOVER: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    pending_d      = enter_refresh ? 1'b0 : (pending_q || enable_refresh);
    write_flag_d   = (state_d == ST_WRITE_BURST);
    read_flag_d    = (state_d == ST_READ_BURST);
    refresh_mode_d = (state_d == ST_REFRESH);
    idle_d         = (state_d == ST_IDLE) && !pending_d;
    dout_d         = read_flag_q ? ram_rdata : dout_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      base_q         <= '0;
      len_q          <= '0;
      pending_q      <= 1'b0;
      write_flag_q   <= 1'b0;
      read_flag_q    <= 1'b0;
      refresh_mode_q <= 1'b0;
      idle_q         <= 1'b1;
      dout_q         <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      base_q         <= base_d;
      len_q          <= len_d;
      pending_q      <= pending_d;
      write_flag_q   <= write_flag_d;
      read_flag_q    <= read_flag_d;
      refresh_mode_q <= refresh_mode_d;
      idle_q         <= idle_d;
      dout_q         <= dout_d;
    end
  end

  assign write_flag   = write_flag_q;
  assign read_flag    = read_flag_q;
  assign refresh_mode = refresh_mode_q;
  assign idle         = idle_q;
  assign data_out     = read_flag_q ? ram_rdata : dout_q;

endmodule

// File: tb/tb_bram_access_responder.sv
// Randomized self-checking bench for bram_access_responder against a
// word-addressed memory model with latency rules derived from the parameters.
module tb_bram_access_responder;

  localparam int WL    = 2;
  localparam int RL    = 3;
  localparam int RC    = 8;
  localparam int DEPTH = 1 << 16;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [24:0] address;
  logic [9:0]  access_num;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        write_request;
  logic        read_request;
  logic        enable_refresh;
  logic        write_flag;
  logic        read_flag;
  logic        idle;
  logic        refresh_mode;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] model_mem [int];
  int          wr_bases [$];
  int          wr_lens  [$];

  bram_access_responder #(
    .ADDR_WIDTH(16), .WRITE_LATENCY(WL), .READ_LATENCY(RL), .REFRESH_CYCLES(RC)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .address        (address),
    .access_num     (access_num),
    .data_in        (data_in),
    .data_out       (data_out),
    .write_request  (write_request),
    .read_request   (read_request),
    .enable_refresh (enable_refresh),
    .write_flag     (write_flag),
    .read_flag      (read_flag),
    .idle           (idle),
    .refresh_mode   (refresh_mode)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic wait_idle();
    int c = 0;
    while (!idle && c < 100) begin
      @(negedge clock);
      c++;
    end
    check("idle_wait", 32'(idle), 1);
  endtask

  // seed < 0 selects random data, otherwise word i carries seed+i.
  task automatic do_write(input logic [24:0] a, input logic [9:0] n_raw,
                          input int exp_lat, input logic [31:0] rf_mask, input int seed);
    int n, lat, i, base;
    logic saw_rd;
    n    = (n_raw == 0) ? 1 : int'(n_raw);
    base = int'(a[15:0]);
    address       = a;
    access_num    = n_raw;
    write_request = 1'b1;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!write_flag && lat < 200);
    check("wr_latency", lat, exp_lat);
    i = 0;
    saw_rd = 1'b0;
    while (write_flag && i < 1100) begin
      data_in = (seed >= 0) ? 16'(seed + i) : 16'($urandom);
      model_mem[(base + i) % DEPTH] = data_in;
      write_request  = 1'b0;
      address        = 25'($urandom);
      access_num     = 10'($urandom);
      enable_refresh = (i < 32) ? rf_mask[i] : 1'b0;
      saw_rd |= read_flag;
      @(negedge clock);
      i++;
    end
    enable_refresh = 1'b0;
    write_request  = 1'b0;
    check("wr_len", i, n);
    check("wr_no_rdflag", 32'(saw_rd), 0);
    wr_bases.push_back(base);
    wr_lens.push_back(n);
  endtask

  // abort_at >= 0 asserts reset_n while word abort_at is on the bus.
  task automatic do_read(input logic [24:0] a, input logic [9:0] n_raw,
                         input int exp_lat, input int abort_at);
    int n, lat, i, base, idx;
    logic have_last;
    logic [15:0] last_exp;
    n    = (n_raw == 0) ? 1 : int'(n_raw);
    base = int'(a[15:0]);
    address      = a;
    access_num   = n_raw;
    read_request = 1'b1;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!read_flag && lat < 200);
    check("rd_latency", lat, exp_lat);
    i = 0;
    have_last = 1'b0;
    last_exp  = '0;
    while (read_flag && i < 1100) begin
      read_request = 1'b0;
      address      = 25'($urandom);
      access_num   = 10'($urandom);
      if (i == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("rst_rdflag", 32'(read_flag), 0);
        check("rst_wrflag", 32'(write_flag), 0);
        check("rst_dout", 32'(data_out), 0);
        return;
      end
      idx = (base + i) % DEPTH;
      have_last = model_mem.exists(idx);
      if (have_last) begin
        last_exp = model_mem[idx];
        check("rd_data", 32'(data_out), 32'(last_exp));
      end
      @(negedge clock);
      i++;
    end
    read_request = 1'b0;
    check("rd_len", i, n);
    if (have_last) check("rd_hold", 32'(data_out), 32'(last_exp));
  endtask

  initial begin
    int rf, k;
    reset_n        = 1'b0;
    address        = '0;
    access_num     = '0;
    data_in        = '0;
    write_request  = 1'b0;
    read_request   = 1'b0;
    enable_refresh = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_idle", 32'(idle), 1);
    check("rst_wflag", 32'(write_flag), 0);
    check("rst_rflag", 32'(read_flag), 0);
    check("rst_refresh", 32'(refresh_mode), 0);
    check("rst_data_out", 32'(data_out), 0);

    // Single-word write then read, upper address bits ignored on the read.
    do_write(25'h0000123, 10'd1, WL + 1, 32'h0, 16'h00A5);
    check("recover_idle", 32'(idle), 0);
    @(negedge clock);
    check("idle_after_recover", 32'(idle), 1);
    do_read(25'h1AB0123, 10'd1, RL + 1, -1);
    check("a5_readback", 32'(data_out), 32'h00A5);
    wait_idle();

    // Wrapping burst across the top of memory.
    do_write(25'h000FFFE, 10'd4, WL + 1, 32'h0, 1);
    wait_idle();
    do_read(25'h000FFFE, 10'd4, RL + 1, -1);
    wait_idle();
    do_read(25'h0000000, 10'd2, RL + 1, -1);
    wait_idle();

    // Refresh pulse coincident with a write request: refresh goes first.
    enable_refresh = 1'b1;
    write_request  = 1'b1;
    address        = 25'h0004000;
    access_num     = 10'd1;
    @(negedge clock);
    enable_refresh = 1'b0;
    check("rf_idle_low", 32'(idle), 0);
    rf = 0;
    while (refresh_mode && rf < 50) begin
      rf++;
      @(negedge clock);
    end
    check("rf_len", rf, RC);
    check("rf_wr_waits", 32'(write_flag), 0);
    do_write(25'h0004000, 10'd1, WL + 2, 32'h0, -1);
    wait_idle();

    // Two pulses during a burst collapse into one refresh window.
    do_write(25'h0005000, 10'd6, WL + 1, 32'b1010, -1);
    rf = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (refresh_mode) rf++;
    end
    check("rf_collapse", rf, RC);
    wait_idle();

    // Both requests: write first, read after RECOVER.
    read_request = 1'b1;
    do_write(25'h0006000, 10'd2, WL + 1, 32'h0, -1);
    do_read(25'h0006000, 10'd2, RL + 2, -1);
    wait_idle();

    // Reset during word 2 of a 4-word read; memory survives.
    do_write(25'h0007000, 10'd4, WL + 1, 32'h0, -1);
    wait_idle();
    do_read(25'h0007000, 10'd4, RL + 1, 2);
    read_request = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_idle", 32'(idle), 1);
    check("post_rst_rflag", 32'(read_flag), 0);
    check("post_rst_dout", 32'(data_out), 0);
    do_read(25'h0007000, 10'd4, RL + 1, -1);
    wait_idle();
    do_read(25'h0000123, 10'd1, RL + 1, -1);
    wait_idle();

    // Randomized mix of writes (some with refresh pulses) and read-backs.
    for (int it = 0; it < 40; it++) begin
      logic [15:0] b;
      if ($urandom_range(0, 1) == 0) begin
        b = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFF - $urandom_range(0, 5))
                                        : 16'($urandom);
        do_write({9'($urandom), b}, 10'($urandom_range(0, 8)), WL + 1,
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : 32'h0, -1);
      end else begin
        k = $urandom_range(0, wr_bases.size() - 1);
        b = 16'(wr_bases[k]);
        do_read({9'($urandom), b}, 10'(wr_lens[k]), RL + 1, -1);
      end
      wait_idle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
